keystream_xor: RTL and testbench
================================

KEYSTREAM_XOR -- requirements
Module: keystream_xor

Interface
REQ-001 SHALL provide parameter DATA_SIZE, default 8, bits per byte lane.
REQ-002 SHALL provide parameter NUM_MATRICES, default 1, keystream blocks delivered per load.
REQ-003 SHALL provide parameter NO_REG, default 64*NUM_MATRICES, bytes per keystream load.
REQ-004 SHALL provide parameter LANES, default 4, bytes per stream beat; NO_REG % LANES == 0 is required, with an elaboration-time check.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port ks_in, input, NO_REG x DATA_SIZE unpacked array [0:NO_REG-1], keystream bytes.
REQ-008 SHALL have ports ks_valid (input, 1) and ks_ready (output, 1), the keystream load handshake.
REQ-009 SHALL have ports pt_data (input, LANES x DATA_SIZE array [0:LANES-1]), pt_keep (input, LANES), pt_last (input, 1) and pt_valid (input, 1), the plaintext/ciphertext-in beat.
REQ-010 SHALL have port pt_ready, output, 1, the input beat accept.
REQ-011 SHALL have ports ct_data (output, LANES x DATA_SIZE), ct_keep (output, LANES), ct_last (output, 1) and ct_valid (output, 1), the result beat.
REQ-012 SHALL have port ct_ready, input, 1, downstream accept.
REQ-013 SHALL have port blk_cnt, output, 32, keystream loads consumed in the current message.

Function
REQ-014 SHALL implement states IDLE and XOR; reset state is IDLE.
REQ-015 In IDLE, ks_ready SHALL be 1; ks_valid&&ks_ready stores ks_in in the buffer, clears byte pointer ptr to 0 and moves to XOR next cycle.
REQ-016 In XOR, ks_ready SHALL be 0 and ks_valid SHALL be ignored.
REQ-017 pt_ready SHALL equal (state==XOR) && (!ct_valid || ct_ready).
REQ-018 On a pt_valid&&pt_ready transfer, the block SHALL register ct_data[j] = pt_keep[j] ? pt_data[j]^buf[ptr+j] : 0 for each lane j, copy keep/last, and set ct_valid, giving exactly one cycle of latency.
REQ-019 ct_valid SHALL hold with data stable until ct_ready; it SHALL clear on ct_ready when no new transfer occurs the same cycle; back-to-back transfers SHALL sustain one beat per cycle.
REQ-020 ptr SHALL advance by LANES per transfer regardless of pt_keep; a partial-keep beat consumes a full LANES keystream slice.
REQ-021 Block end: a transfer with ptr==NO_REG-LANES SHALL return to IDLE, increment blk_cnt, and stall pt_ready until the next load.
REQ-022 A pt_last transfer SHALL discard the remaining keystream, return to IDLE and clear blk_cnt to 0, including when it coincides with block end.
REQ-023 blk_cnt SHALL wrap from 2^32-1 to 0.
REQ-024 A pt_valid in IDLE SHALL NOT be accepted and SHALL NOT alter state.

Reset
REQ-025 rst SHALL, on the next clk edge, set state=IDLE, ptr=0, blk_cnt=0, ct_valid=0, ct_last=0, ct_keep=0 and ct_data=0; the keystream buffer need not clear.
REQ-026 rst asserted mid-message SHALL drop any pending ct beat and discard the buffered keystream; the first post-reset transfer requires a new load.

Structure
REQ-027 A shared package SHALL hold the state enum type (IDLE, XOR) and the localparam for blk_cnt width (32).
REQ-028 The design SHALL have one sub-module, ks_buffer, owning the NO_REG-byte storage, ptr and LANES-wide slice read; the FSM, handshake and output register SHALL live in keystream_xor.

Verification
REQ-029 Load ks_in[i]=i; 16 full beats, pt_data=8'hFF, keep=4'hF, ct_ready=1 -> ct_data[j]=8'hFF^(4k+j) on beat k; blk_cnt=1 after beat 15; ks_ready=1.
REQ-030 Hold ct_ready=0 for 3 cycles mid-stream -> ct_data stable, pt_ready=0, no beat lost or duplicated.
REQ-031 pt_last on beat 5 with keep=4'b0011 -> ct_keep=4'b0011, lanes 2-3=0, ct_last=1, state IDLE, blk_cnt=0.
REQ-032 Assert pt_valid before any load -> pt_ready=0 until a load completes; then the first ct uses ks_in[0..3].
REQ-033 Assert rst at beat 7 -> next cycle ct_valid=0, ks_ready=1, blk_cnt=0; a new load then restarts from ptr=0.
REQ-034 Run with NUM_MATRICES=2, LANES=8, and pt_last on beat 15 (final slice) -> 16 beats per load, blk_cnt returns to 0.

Source files
------------

// File: rtl/keystream_xor_pkg.sv
// Keystream XOR shared types and constants.
// Holds the FSM state type and the block counter width.
package keystream_xor_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XOR  = 1'b1
   } state_t;

   localparam int BLK_CNT_W = 32;

endpackage

// File: rtl/keystream_xor_ks_buffer.sv
// Keystream storage with byte pointer.
// Presents the LANES-wide slice starting at ptr.
module ks_buffer #(
   parameter int DATA_SIZE = 8,
   parameter int NO_REG    = 64,
   parameter int LANES     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 adv,
   input  logic [DATA_SIZE-1:0] ks_in [0:NO_REG-1],
   output logic [DATA_SIZE-1:0] slice [0:LANES-1],
   output logic                 at_end
);

   localparam int PW = (NO_REG > 1) ? $clog2(NO_REG) : 1;

   logic [DATA_SIZE-1:0] mem [0:NO_REG-1];
   logic [PW-1:0]        ptr;

   // capture a whole keystream load; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (load) mem <= ks_in;
   end

   // byte pointer: restarts on every load, steps one full slice per beat
   always_ff @(posedge clk) begin
      if (rst) ptr <= '0;
      else if (load) ptr <= '0;
      else if (adv) ptr <= ptr + PW'(LANES);
   end

   for (genvar j = 0; j < LANES; j++) begin : g_slice
      assign slice[j] = mem[ptr + PW'(j)];
   end

   assign at_end = (ptr == PW'(NO_REG - LANES));

endmodule

// File: rtl/keystream_xor.sv
// Streams beats through an XOR with a buffered keystream.
// One load covers NO_REG bytes; pt_last ends the message.
module keystream_xor
   import keystream_xor_pkg::*;
#(
   parameter int DATA_SIZE    = 8,
   parameter int NUM_MATRICES = 1,
   parameter int NO_REG       = 64 * NUM_MATRICES,
   parameter int LANES        = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] ks_in [0:NO_REG-1],
   input  logic                 ks_valid,
   output logic                 ks_ready,
   input  logic [DATA_SIZE-1:0] pt_data [0:LANES-1],
   input  logic [LANES-1:0]     pt_keep,
   input  logic                 pt_last,
   input  logic                 pt_valid,
   output logic                 pt_ready,
   output logic [DATA_SIZE-1:0] ct_data [0:LANES-1],
   output logic [LANES-1:0]     ct_keep,
   output logic                 ct_last,
   output logic                 ct_valid,
   input  logic                 ct_ready,
   output logic [BLK_CNT_W-1:0] blk_cnt
);

   if (NO_REG % LANES != 0) begin : g_bad_lanes
      $error("NO_REG must be a multiple of LANES");
   end

   state_t state, state_n;
   logic   load;
   logic   xfer;
   logic   at_end;
   logic [DATA_SIZE-1:0] slice [0:LANES-1];

   ks_buffer #(
      .DATA_SIZE (DATA_SIZE),
      .NO_REG    (NO_REG),
      .LANES     (LANES)
   ) u_buf (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .adv    (xfer),
      .ks_in  (ks_in),
      .slice  (slice),
      .at_end (at_end)
   );

   assign xfer = pt_valid && pt_ready;

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end

   // next state and handshakes; a load is only taken in IDLE
   always_comb begin
      state_n  = state;
      ks_ready = 1'b0;
      pt_ready = 1'b0;
      load     = 1'b0;
      unique case (state)
         IDLE: begin
            ks_ready = 1'b1;
            if (ks_valid) begin
               load    = 1'b1;
               state_n = XOR;
            end
         end
         XOR: begin
            pt_ready = !ct_valid || ct_ready;
            if (pt_valid && pt_ready && (pt_last || at_end)) state_n = IDLE;
         end
      endcase
   end

   // output beat register: load on transfer, hold until accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         ct_valid <= 1'b0;
         ct_last  <= 1'b0;
         ct_keep  <= '0;
         for (int j = 0; j < LANES; j++) ct_data[j] <= '0;
      end else if (xfer) begin
         ct_valid <= 1'b1;
         ct_last  <= pt_last;
         ct_keep  <= pt_keep;
         for (int j = 0; j < LANES; j++)
            ct_data[j] <= pt_keep[j] ? (pt_data[j] ^ slice[j]) : '0;
      end else if (ct_ready) begin
         ct_valid <= 1'b0;
      end
   end

   // loads consumed in this message; a last beat restarts the count
   always_ff @(posedge clk) begin
      if (rst) blk_cnt <= '0;
      else if (xfer) begin
         if (pt_last) blk_cnt <= '0;
         else if (at_end) blk_cnt <= blk_cnt + BLK_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_keystream_xor.sv
// Directed bench for keystream_xor: default build plus an
// 8-lane, two-matrix build sharing clock and reset.
module tb_keystream_xor;

   logic clk;
   logic rst;

   logic [7:0]  ks_in [0:63];
   logic        ks_valid, ks_ready;
   logic [7:0]  pt_data [0:3];
   logic [3:0]  pt_keep;
   logic        pt_last, pt_valid, pt_ready;
   logic [7:0]  ct_data [0:3];
   logic [3:0]  ct_keep;
   logic        ct_last, ct_valid, ct_ready;
   logic [31:0] blk_cnt;

   logic [7:0]  ks_in2 [0:127];
   logic        ks_valid2, ks_ready2;
   logic [7:0]  pt_data2 [0:7];
   logic [7:0]  pt_keep2;
   logic        pt_last2, pt_valid2, pt_ready2;
   logic [7:0]  ct_data2 [0:7];
   logic [7:0]  ct_keep2;
   logic        ct_last2, ct_valid2, ct_ready2;
   logic [31:0] blk_cnt2;

   int checks = 0;
   int failures = 0;

   keystream_xor dut (
      .clk(clk), .rst(rst),
      .ks_in(ks_in), .ks_valid(ks_valid), .ks_ready(ks_ready),
      .pt_data(pt_data), .pt_keep(pt_keep), .pt_last(pt_last),
      .pt_valid(pt_valid), .pt_ready(pt_ready),
      .ct_data(ct_data), .ct_keep(ct_keep), .ct_last(ct_last),
      .ct_valid(ct_valid), .ct_ready(ct_ready), .blk_cnt(blk_cnt)
   );

   keystream_xor #(.NUM_MATRICES(2), .LANES(8)) dut2 (
      .clk(clk), .rst(rst),
      .ks_in(ks_in2), .ks_valid(ks_valid2), .ks_ready(ks_ready2),
      .pt_data(pt_data2), .pt_keep(pt_keep2), .pt_last(pt_last2),
      .pt_valid(pt_valid2), .pt_ready(pt_ready2),
      .ct_data(ct_data2), .ct_keep(ct_keep2), .ct_last(ct_last2),
      .ct_valid(ct_valid2), .ct_ready(ct_ready2), .blk_cnt(blk_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pt;
      logic [3:0]  keep;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ct_word();
      logic [31:0] w;
      for (int j = 0; j < 4; j++) w[8*j +: 8] = ct_data[j];
      return w;
   endfunction

   function automatic logic [63:0] ct_word2();
      logic [63:0] w;
      for (int j = 0; j < 8; j++) w[8*j +: 8] = ct_data2[j];
      return w;
   endfunction

   // expected beat k of a load whose byte i is base+i
   function automatic logic [31:0] model(input logic [7:0] base, input int k,
                                         input logic [31:0] pt,
                                         input logic [3:0] keep);
      logic [31:0] w;
      for (int j = 0; j < 4; j++) begin
         logic [7:0] kb;
         kb = base + 8'(4 * k + j);
         w[8*j +: 8] = keep[j] ? (pt[8*j +: 8] ^ kb) : 8'h00;
      end
      return w;
   endfunction

   task automatic load_ks(input logic [7:0] base);
      for (int i = 0; i < 64; i++) ks_in[i] = base + 8'(i);
      ks_valid = 1'b1;
      #1;
      chk("ks_ready_at_load", 64'(ks_ready), 64'd1);
      @(negedge clk);
      ks_valid = 1'b0;
   endtask

   // drive at negedge, wait (bounded) for acceptance, return at the
   // negedge after the transfer edge
   task automatic send(input logic [31:0] pt, input logic [3:0] keep,
                       input logic last);
      int n;
      for (int j = 0; j < 4; j++) pt_data[j] = pt[8*j +: 8];
      pt_keep  = keep;
      pt_last  = last;
      pt_valid = 1'b1;
      #1;
      n = 0;
      while (!pt_ready && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!pt_ready) begin
         failures++;
         $display("FAIL pt_ready_timeout actual=0 required=1");
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send2(input logic [63:0] pt, input logic last);
      int n;
      for (int j = 0; j < 8; j++) pt_data2[j] = pt[8*j +: 8];
      pt_keep2  = 8'hFF;
      pt_last2  = last;
      pt_valid2 = 1'b1;
      #1;
      n = 0;
      while (!pt_ready2 && n < 20) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!pt_ready2) begin
         failures++;
         $display("FAIL pt_ready2_timeout actual=0 required=1");
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] e2;

      tbl[0]  = '{32'hFFFFFFFF, 4'hF, 32'hFCFDFEFF};
      tbl[1]  = '{32'hFFFFFFFF, 4'hF, 32'hF8F9FAFB};
      tbl[2]  = '{32'h00000000, 4'hF, 32'h0B0A0908};
      tbl[3]  = '{32'hA5A5A5A5, 4'hF, 32'hAAABA8A9};
      tbl[4]  = '{32'hFFFFFFFF, 4'h5, 32'h00ED00EF};
      tbl[5]  = '{32'h12345678, 4'hF, 32'h0522436C};
      tbl[6]  = '{32'hFFFFFFFF, 4'h0, 32'h00000000};
      tbl[7]  = '{32'hFFFFFFFF, 4'hF, 32'hE0E1E2E3};
      tbl[8]  = '{32'hFFFFFFFF, 4'hF, 32'hDCDDDEDF};
      tbl[9]  = '{32'hFFFFFFFF, 4'hF, 32'hD8D9DADB};
      tbl[10] = '{32'hFFFFFFFF, 4'hF, 32'hD4D5D6D7};
      tbl[11] = '{32'hFFFFFFFF, 4'hF, 32'hD0D1D2D3};
      tbl[12] = '{32'hFFFFFFFF, 4'hF, 32'hCCCDCECF};
      tbl[13] = '{32'hFFFFFFFF, 4'hF, 32'hC8C9CACB};
      tbl[14] = '{32'hFFFFFFFF, 4'hF, 32'hC4C5C6C7};
      tbl[15] = '{32'hFFFFFFFF, 4'hF, 32'hC0C1C2C3};

      rst = 1'b1;
      ks_valid = 1'b0; pt_keep = '0; pt_last = 1'b0; pt_valid = 1'b0;
      ct_ready = 1'b1;
      ks_valid2 = 1'b0; pt_keep2 = '0; pt_last2 = 1'b0; pt_valid2 = 1'b0;
      ct_ready2 = 1'b1;
      for (int i = 0; i < 64; i++) ks_in[i] = '0;
      for (int i = 0; i < 128; i++) ks_in2[i] = '0;
      for (int j = 0; j < 4; j++) pt_data[j] = '0;
      for (int j = 0; j < 8; j++) pt_data2[j] = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ct_valid", 64'(ct_valid), 64'd0);
      chk("rst_ct_last", 64'(ct_last), 64'd0);
      chk("rst_ct_keep", 64'(ct_keep), 64'd0);
      chk("rst_ct_data", 64'(ct_word()), 64'd0);
      chk("rst_blk_cnt", 64'(blk_cnt), 64'd0);
      chk("rst_ks_ready", 64'(ks_ready), 64'd1);
      chk("rst_pt_ready", 64'(pt_ready), 64'd0);
      @(negedge clk);

      // pt_valid before any load is held off
      for (int j = 0; j < 4; j++) pt_data[j] = 8'hFF;
      pt_keep = 4'hF;
      pt_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("idle_pt_ready", 64'(pt_ready), 64'd0);
         chk("idle_ct_valid", 64'(ct_valid), 64'd0);
         @(negedge clk);
      end
      load_ks(8'h00);

      // full block from the vector table, back-to-back
      for (int k = 0; k < 16; k++) begin
         send(tbl[k].pt, tbl[k].keep, 1'b0);
         chk($sformatf("tbl%0d_valid", k), 64'(ct_valid), 64'd1);
         chk($sformatf("tbl%0d_data", k), 64'(ct_word()), 64'(tbl[k].exp));
         chk($sformatf("tbl%0d_keep", k), 64'(ct_keep), 64'(tbl[k].keep));
         chk($sformatf("tbl%0d_last", k), 64'(ct_last), 64'd0);
      end
      pt_valid = 1'b0;
      #1;
      chk("blkend_cnt", 64'(blk_cnt), 64'd1);
      chk("blkend_ks_ready", 64'(ks_ready), 64'd1);
      chk("blkend_pt_ready", 64'(pt_ready), 64'd0);
      @(negedge clk);

      // downstream stall: beat 0 held, beat 1 waits, then flows once
      load_ks(8'h00);
      send(32'hFFFFFFFF, 4'hF, 1'b0);
      chk("stall_b0", 64'(ct_word()), 64'hFCFDFEFF);
      ct_ready = 1'b0;
      for (int j = 0; j < 4; j++) pt_data[j] = 8'h00;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("stall_pt_ready", 64'(pt_ready), 64'd0);
         chk("stall_valid", 64'(ct_valid), 64'd1);
         chk("stall_data", 64'(ct_word()), 64'hFCFDFEFF);
         @(negedge clk);
      end
      ct_ready = 1'b1;
      send(32'h00000000, 4'hF, 1'b0);
      chk("stall_b1", 64'(ct_word()), 64'h07060504);
      pt_valid = 1'b0;
      @(negedge clk);
      chk("stall_drain", 64'(ct_valid), 64'd0);

      // early last with a partial keep, mid-block, blk_cnt was 1
      send(32'hFFFFFFFF, 4'hF, 1'b0);
      chk("last_b2", 64'(ct_word()), 64'hF4F5F6F7);
      send(32'hFFFFFFFF, 4'hF, 1'b0);
      chk("last_b3", 64'(ct_word()), 64'hF0F1F2F3);
      send(32'hFFFFFFFF, 4'hF, 1'b0);
      chk("last_b4", 64'(ct_word()), 64'hECEDEEEF);
      send(32'hFFFFFFFF, 4'b0011, 1'b1);
      pt_valid = 1'b0;
      pt_last = 1'b0;
      #1;
      chk("last_data", 64'(ct_word()), 64'h0000EAEB);
      chk("last_keep", 64'(ct_keep), 64'h3);
      chk("last_flag", 64'(ct_last), 64'd1);
      chk("last_ks_ready", 64'(ks_ready), 64'd1);
      chk("last_blk_cnt", 64'(blk_cnt), 64'd0);
      @(negedge clk);

      // reset mid-message after one completed block
      load_ks(8'h40);
      for (int k = 0; k < 16; k++) begin
         send(32'h5A5A5A5A, 4'hF, 1'b0);
         chk($sformatf("r1_b%0d", k), 64'(ct_word()),
             64'(model(8'h40, k, 32'h5A5A5A5A, 4'hF)));
      end
      pt_valid = 1'b0;
      load_ks(8'h80);
      for (int k = 0; k < 7; k++) begin
         send(32'hC3C3C3C3, 4'hF, 1'b0);
         chk($sformatf("r2_b%0d", k), 64'(ct_word()),
             64'(model(8'h80, k, 32'hC3C3C3C3, 4'hF)));
      end
      chk("pre_rst_blk_cnt", 64'(blk_cnt), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      pt_valid = 1'b0;
      #1;
      chk("midrst_ct_valid", 64'(ct_valid), 64'd0);
      chk("midrst_ks_ready", 64'(ks_ready), 64'd1);
      chk("midrst_blk_cnt", 64'(blk_cnt), 64'd0);
      chk("midrst_pt_ready", 64'(pt_ready), 64'd0);
      @(negedge clk);
      load_ks(8'h20);
      send(32'hFFFFFFFF, 4'hF, 1'b0);
      pt_valid = 1'b0;
      chk("postrst_b0", 64'(ct_word()), 64'hDCDDDEDF);
      @(negedge clk);

      // 8-lane build, 128-byte load: 16 beats, last on the final slice
      for (int i = 0; i < 128; i++) ks_in2[i] = 8'(i);
      ks_valid2 = 1'b1;
      @(negedge clk);
      ks_valid2 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         send2(64'hFFFFFFFFFFFFFFFF, k == 15);
         for (int j = 0; j < 8; j++) e2[8*j +: 8] = ~8'(8 * k + j);
         chk($sformatf("w8_b%0d", k), ct_word2(), e2);
         if (k == 14) begin
            #1;
            chk("w8_b14_pt_ready", 64'(pt_ready2), 64'd1);
         end
      end
      pt_valid2 = 1'b0;
      pt_last2 = 1'b0;
      #1;
      chk("w8_last", 64'(ct_last2), 64'd1);
      chk("w8_blk_cnt", 64'(blk_cnt2), 64'd0);
      chk("w8_ks_ready", 64'(ks_ready2), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
